lms_fir: RTL

Adaptive FIR filter with LMS coefficient update: a parametrised successor to the fixed-coefficient transposed FIR in the adaptive-filter datapath.
- Filters one sample per transaction with a valid/ready handshake.
- Produces a rounded, saturated output and the error against a desired sample.
- Optionally adapts its own coefficients with a power-of-two step size.
- Coefficients can also be written from outside and are exposed for observation.

---
 rtl/lms_fir.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lms_fir.sv
// Adaptive FIR filter with LMS coefficient update and external coefficient writes.
// One sample per four cycles: IDLE (accept), MAC, OUT (round/saturate), UPDATE (adapt).
module lms_fir #(
   parameter int DIN_WIDTH   = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int DOUT_WIDTH  = 16,
   parameter int TAPS        = 16,
   parameter int MU_SHIFT    = 8
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              din_valid,
   output logic                              din_ready,
   input  logic signed [DIN_WIDTH-1:0]       din,
   input  logic signed [DIN_WIDTH-1:0]       desired,
   input  logic                              adapt_en,
   input  logic                              coeff_wr,
   input  logic [$clog2(TAPS)-1:0]           coeff_idx,
   input  logic signed [COEFF_WIDTH-1:0]     coeff_wdata,
   output logic                              dout_valid,
   output logic signed [DOUT_WIDTH-1:0]      dout,
   output logic signed [DOUT_WIDTH-1:0]      err,
   output logic [TAPS*COEFF_WIDTH-1:0]       coeffs
);

   localparam int IDX_W = $clog2(TAPS);
   localparam int ACC_W = DIN_WIDTH + COEFF_WIDTH + IDX_W;
   localparam int RND_W = ACC_W + 2;
   localparam int UPD_W = DIN_WIDTH + DOUT_WIDTH + COEFF_WIDTH + 1;

   localparam logic signed [RND_W-1:0] DOUT_MAX  = {{(RND_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [RND_W-1:0] DOUT_MIN  = ~DOUT_MAX;
   localparam logic signed [UPD_W-1:0] COEFF_MAX = {{(UPD_W-COEFF_WIDTH+1){1'b0}}, {(COEFF_WIDTH-1){1'b1}}};
   localparam logic signed [UPD_W-1:0] COEFF_MIN = ~COEFF_MAX;
   localparam logic signed [RND_W-1:0] RND_OFS   = {{(RND_W-COEFF_WIDTH+1){1'b0}}, 1'b1, {(COEFF_WIDTH-2){1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      OUT    = 2'd2,
      UPDATE = 2'd3
   } state_t;

   function automatic logic signed [DOUT_WIDTH-1:0] sat_dout(input logic signed [RND_W-1:0] v);
      logic signed [DOUT_WIDTH-1:0] r;
      if (v > DOUT_MAX) begin
         r = DOUT_MAX[DOUT_WIDTH-1:0];
      end else if (v < DOUT_MIN) begin
         r = DOUT_MIN[DOUT_WIDTH-1:0];
      end else begin
         r = v[DOUT_WIDTH-1:0];
      end
      return r;
   endfunction

   function automatic logic signed [COEFF_WIDTH-1:0] sat_coeff(input logic signed [UPD_W-1:0] v);
      logic signed [COEFF_WIDTH-1:0] r;
      if (v > COEFF_MAX) begin
         r = COEFF_MAX[COEFF_WIDTH-1:0];
      end else if (v < COEFF_MIN) begin
         r = COEFF_MIN[COEFF_WIDTH-1:0];
      end else begin
         r = v[COEFF_WIDTH-1:0];
      end
      return r;
   endfunction

   state_t                         state_r, state_nxt_s;
   logic signed [DIN_WIDTH-1:0]    x_r [TAPS];
   logic signed [COEFF_WIDTH-1:0]  c_r [TAPS];
   logic signed [COEFF_WIDTH-1:0]  c_next_s [TAPS];
   logic signed [UPD_W-1:0]        prod_s [TAPS];
   logic signed [UPD_W-1:0]        delta_s [TAPS];
   logic signed [ACC_W-1:0]        acc_r, mac_s;
   logic signed [DIN_WIDTH-1:0]    desired_r;
   logic signed [RND_W-1:0]        rnd_s, diff_s;
   logic signed [DOUT_WIDTH-1:0]   y_s, err_s;
   logic signed [DOUT_WIDTH-1:0]   dout_r, err_r;
   logic                           dout_valid_r;
   logic                           accept_s, wr_ok_s;

   assign din_ready  = (state_r == IDLE);
   assign accept_s   = din_valid && (state_r == IDLE);
   assign wr_ok_s    = coeff_wr && (state_r == IDLE) && (32'(coeff_idx) < TAPS);
   assign dout       = dout_r;
   assign err        = err_r;
   assign dout_valid = dout_valid_r;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (din_valid) begin
               state_nxt_s = MAC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MAC:     state_nxt_s = OUT;
         OUT:     state_nxt_s = UPDATE;
         UPDATE:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Full-precision dot product, round-half-up/saturate, and per-tap LMS step.
   always_comb begin
      mac_s = '0;
      for (int k = 0; k < TAPS; k++) begin
         mac_s       = mac_s + (ACC_W'(x_r[k]) * ACC_W'(c_r[k]));
         prod_s[k]   = UPD_W'(err_r) * UPD_W'(x_r[k]);
         delta_s[k]  = prod_s[k] >>> (DIN_WIDTH - 1 + MU_SHIFT);
         c_next_s[k] = sat_coeff(UPD_W'(c_r[k]) + delta_s[k]);
      end
      rnd_s  = (RND_W'(acc_r) + RND_OFS) >>> (COEFF_WIDTH - 1);
      y_s    = sat_dout(rnd_s);
      diff_s = RND_W'(desired_r) - RND_W'(y_s);
      err_s  = sat_dout(diff_s);
   end

   // Delay line and reference capture on acceptance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < TAPS; k++) begin
            x_r[k] <= '0;
         end
         desired_r <= '0;
      end else if (accept_s) begin
         x_r[0] <= din;
         for (int k = 1; k < TAPS; k++) begin
            x_r[k] <= x_r[k-1];
         end
         desired_r <= desired;
      end else begin
         desired_r <= desired_r;
      end
   end

   // Coefficients: external writes only in IDLE, adaptation only in UPDATE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < TAPS; k++) begin
            c_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            if (wr_ok_s && (coeff_idx == IDX_W'(k))) begin
               c_r[k] <= coeff_wdata;
            end else if ((state_r == UPDATE) && adapt_en) begin
               c_r[k] <= c_next_s[k];
            end else begin
               c_r[k] <= c_r[k];
            end
         end
      end
   end

   // Accumulator and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_r        <= '0;
         dout_r       <= '0;
         err_r        <= '0;
         dout_valid_r <= 1'b0;
      end else begin
         dout_valid_r <= (state_r == OUT);
         if (state_r == MAC) begin
            acc_r <= mac_s;
         end else begin
            acc_r <= acc_r;
         end
         if (state_r == OUT) begin
            dout_r <= y_s;
            err_r  <= err_s;
         end else begin
            dout_r <= dout_r;
            err_r  <= err_r;
         end
      end
   end

   // Flatten coefficient registers for observation.
   always_comb begin
      coeffs = '0;
      for (int k = 0; k < TAPS; k++) begin
         coeffs[k*COEFF_WIDTH +: COEFF_WIDTH] = c_r[k];
      end
   end

endmodule
